iserdes_word_aligner: RTL and testbench



---
 rtl/iserdes_word_aligner.sv | 139 +++++++++++++
 tb/tb_iserdes_word_aligner.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iserdes_word_aligner.sv
// Word aligner for a 1:N input deserializer: hunts for TRAIN_PATTERN by pulsing
// bitslip, then declares lock and forwards data words with a registered valid.
module iserdes_word_aligner #(
  parameter int unsigned             WIDTH         = 4,
  parameter logic [WIDTH-1:0]        TRAIN_PATTERN = 4'b0011,
  parameter int unsigned             MATCH_COUNT   = 8,
  parameter int unsigned             SLIP_WAIT     = 4,
  parameter int unsigned             MAX_SLIPS     = 3
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               PLL_LOCK,
  input  logic                               ALIGN_EN,
  input  logic                               DATA_VALID,
  input  logic [WIDTH-1:0]                   Q,
  output logic                               BITSLIP_ADJ,
  output logic                               ALIGNED,
  output logic                               ALIGN_ERR,
  output logic [$clog2(MAX_SLIPS+1)-1:0]     SLIP_COUNT,
  output logic [WIDTH-1:0]                   DATA_OUT,
  output logic                               DATA_OUT_VALID
);

  localparam int unsigned SW = $clog2(MAX_SLIPS + 1);
  localparam logic [SW-1:0] SLIP_MAX = SW'(MAX_SLIPS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] SLIP   = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] LOCKED = 3'd4;
  localparam logic [2:0] ERROR  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [SW-1:0]    slip_cnt_q, slip_cnt_d;
  logic             bitslip_q, bitslip_d;
  logic             aligned_q, aligned_d;
  logic             align_err_q, align_err_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_out_valid_q, data_out_valid_d;

  logic             run;
  logic [8:0]       match_inc;
  logic [8:0]       wait_inc;

  always_comb begin
    run         = PLL_LOCK && ALIGN_EN;
    match_inc   = {1'b0, match_cnt_q} + 9'd1;
    wait_inc    = {1'b0, wait_cnt_q} + 9'd1;
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    slip_cnt_d  = slip_cnt_q;

    if (state_q != IDLE && !run) begin
      // Abort outranks every other transition, including a pending slip.
      state_d     = IDLE;
      match_cnt_d = '0;
      wait_cnt_d  = '0;
      slip_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          match_cnt_d = '0;
          wait_cnt_d  = '0;
          slip_cnt_d  = '0;
          if (run) state_d = CHECK;
        end
        CHECK: begin
          if (DATA_VALID) begin
            if (Q == TRAIN_PATTERN) begin
              match_cnt_d = match_inc[7:0];
              if (match_inc >= 9'(MATCH_COUNT)) state_d = LOCKED;
            end else begin
              match_cnt_d = '0;
              state_d     = (slip_cnt_q == SLIP_MAX) ? ERROR : SLIP;
            end
          end
        end
        SLIP: begin
          if (slip_cnt_q != SLIP_MAX) slip_cnt_d = slip_cnt_q + 1'b1;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
        WAIT: begin
          if (DATA_VALID) begin
            wait_cnt_d = wait_inc[7:0];
            if (wait_inc >= 9'(SLIP_WAIT)) begin
              wait_cnt_d = '0;
              state_d    = CHECK;
            end
          end
        end
        default: ;
      endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    bitslip_d        = (state_d == SLIP);
    aligned_d        = (state_d == LOCKED);
    align_err_d      = (state_d == ERROR);
    data_out_d       = DATA_VALID ? Q : data_out_q;
    data_out_valid_d = DATA_VALID && (state_d == LOCKED);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q          <= IDLE;
      match_cnt_q      <= '0;
      wait_cnt_q       <= '0;
      slip_cnt_q       <= '0;
      bitslip_q        <= 1'b0;
      aligned_q        <= 1'b0;
      align_err_q      <= 1'b0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      match_cnt_q      <= match_cnt_d;
      wait_cnt_q       <= wait_cnt_d;
      slip_cnt_q       <= slip_cnt_d;
      bitslip_q        <= bitslip_d;
      aligned_q        <= aligned_d;
      align_err_q      <= align_err_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
    end
  end

  assign BITSLIP_ADJ    = bitslip_q;
  assign ALIGNED        = aligned_q;
  assign ALIGN_ERR      = align_err_q;
  assign SLIP_COUNT     = slip_cnt_q;
  assign DATA_OUT       = data_out_q;
  assign DATA_OUT_VALID = data_out_valid_q;

endmodule

// File: tb/tb_iserdes_word_aligner.sv
// Bench for iserdes_word_aligner: a behavioural deserializer drives the DUT and a
// per-beat reference model predicts every output after each clock edge.
module tb_iserdes_word_aligner;

  localparam logic [3:0] PAT = 4'b0011;
  localparam int MC  = 8;
  localparam int SWT = 4;
  localparam int MS  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, pll_i, en_i, dv_i;
  logic [3:0] q_i;
  logic       bs_o, al_o, er_o, dov_o;
  logic [1:0] sc_o;
  logic [3:0] do_o;

  iserdes_word_aligner #(
    .WIDTH(4), .TRAIN_PATTERN(PAT), .MATCH_COUNT(MC), .SLIP_WAIT(SWT), .MAX_SLIPS(MS)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .PLL_LOCK(pll_i), .ALIGN_EN(en_i), .DATA_VALID(dv_i),
    .Q(q_i), .BITSLIP_ADJ(bs_o), .ALIGNED(al_o), .ALIGN_ERR(er_o), .SLIP_COUNT(sc_o),
    .DATA_OUT(do_o), .DATA_OUT_VALID(dov_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phases of the alignment procedure, stepped once per edge.
  typedef enum int {M_OFF, M_HUNT, M_PULSE, M_SETTLE, M_LOCK, M_FAIL} mode_t;
  mode_t      m_mode;
  int         m_match, m_disc, m_slips;
  logic [3:0] e_do;
  logic       e_dov;

  task automatic model_reset();
    m_mode = M_OFF; m_match = 0; m_disc = 0; m_slips = 0; e_do = '0; e_dov = 1'b0;
  endtask

  task automatic model_step(input logic pll, input logic en, input logic dv, input logic [3:0] q);
    if (m_mode != M_OFF && !(pll && en)) begin
      m_mode = M_OFF; m_match = 0; m_disc = 0; m_slips = 0;
    end else begin
      case (m_mode)
        M_OFF: begin
          m_match = 0; m_slips = 0; m_disc = 0;
          if (pll && en) m_mode = M_HUNT;
        end
        M_HUNT: if (dv) begin
          if (q == PAT) begin
            m_match++;
            if (m_match == MC) m_mode = M_LOCK;
          end else begin
            m_match = 0;
            m_mode  = (m_slips == MS) ? M_FAIL : M_PULSE;
          end
        end
        M_PULSE: begin
          if (m_slips < MS) m_slips++;
          m_disc = 0;
          m_mode = M_SETTLE;
        end
        M_SETTLE: if (dv) begin
          m_disc++;
          if (m_disc == SWT) m_mode = M_HUNT;
        end
        default: ;
      endcase
    end
    if (dv) e_do = q;
    e_dov = dv && (m_mode == M_LOCK);
  endtask

  // Behavioural deserializer: word is the pattern rotated left by rot bits.
  int         rot = 0, q_mode = 2, dv_pct = 100;
  logic [3:0] q_const = 4'hF;
  bit         bs_seen = 1'b0;
  int         pulses = 0, step_no = 0, last_pulse = 0, pulse_gap = 0;

  function automatic logic [3:0] rotl(input int r);
    logic [7:0] w;
    w = {PAT, PAT};
    w = w >> (4 - r);
    return w[3:0];
  endfunction

  function automatic logic [3:0] gen_q();
    case (q_mode)
      0:       return rotl(rot);
      1:       return q_const;
      default: return 4'($urandom);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(pll_i, en_i, dv_i, q_i);
    if (bs_seen) rot = (rot + 3) % 4;
    #1;
    step_no++;
    check("bitslip", bs_o, m_mode == M_PULSE);
    check("aligned", al_o, m_mode == M_LOCK);
    check("align_err", er_o, m_mode == M_FAIL);
    check("slip_count", sc_o, m_slips);
    check("data_out", do_o, e_do);
    check("data_out_valid", dov_o, e_dov);
    bs_seen = bs_o;
    if (bs_o) begin
      pulses++;
      pulse_gap  = step_no - last_pulse;
      last_pulse = step_no;
    end
    dv_i = ($urandom_range(99) < dv_pct);
    q_i  = gen_q();
  endtask

  task automatic wait_aligned(input int max, input string tag);
    for (int i = 0; i < max && !al_o; i++) step();
    check(tag, al_o, 1);
  endtask

  task automatic wait_pulse(input int max, input string tag);
    step();
    for (int i = 1; i < max && !bs_o; i++) step();
    check(tag, bs_o, 1);
  endtask

  task automatic restart(input int new_rot);
    en_i = 1'b0; rot = new_rot; q_mode = 0; q_i = rotl(rot);
    step();
    en_i = 1'b1; pulses = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lock_steps, p0;
    rst_n = 1'b0; pll_i = 1'b1; en_i = 1'b1; dv_i = 1'b1; q_i = 4'($urandom);
    model_reset();
    for (int i = 0; i < 3; i++) step();

    // Perfect pattern from reset release.
    rst_n = 1'b1; q_mode = 0; rot = 0; dv_pct = 100; dv_i = 1'b1; q_i = rotl(0);
    lock_steps = 0; pulses = 0;
    for (int i = 0; i < 30 && !al_o; i++) begin step(); lock_steps++; end
    check("lock_latency", lock_steps, MC + 1);
    check("no_pulse_when_aligned", pulses, 0);
    check("slip_count_zero", sc_o, 0);
    for (int i = 0; i < 3; i++) step();

    // Rotation offset 2, continuous valid.
    restart(2);
    wait_aligned(80, "lock_rot2");
    check("pulses_rot2", pulses, 2);
    check("pulse_spacing", pulse_gap, SWT + 2);
    check("slip_count_rot2", sc_o, 2);

    // Rotation offset 2, valid toggling.
    dv_pct = 50;
    restart(2);
    wait_aligned(250, "lock_rot2_gaps");
    check("pulses_rot2_gaps", pulses, 2);
    check("slip_count_rot2_gaps", sc_o, 2);
    dv_pct = 100;

    // No rotation matches: error after MAX_SLIPS pulses.
    en_i = 1'b0; q_mode = 1; q_const = 4'hF; q_i = 4'hF;
    step();
    en_i = 1'b1; pulses = 0;
    for (int i = 0; i < 60 && !er_o; i++) step();
    check("align_err_set", er_o, 1);
    check("pulses_err", pulses, MS);
    check("slip_count_err", sc_o, MS);
    for (int i = 0; i < 5; i++) step();
    check("no_pulse_in_error", pulses, MS);
    en_i = 1'b0;
    step();
    check("err_cleared", er_o, 0);
    check("slip_count_cleared", sc_o, 0);

    // Re-enable starts in CHECK: first beat mismatches, then PLL drops during SLIP.
    en_i = 1'b1; q_mode = 0; rot = 2; q_i = rotl(2);
    step();
    step();
    check("restart_in_check", bs_o, 1);
    pll_i = 1'b0; p0 = pulses;
    step();
    check("slip_abort_bitslip", bs_o, 0);
    check("slip_abort_count", sc_o, 0);
    for (int i = 0; i < 4; i++) step();
    check("slip_abort_no_pulse", pulses, p0);
    pll_i = 1'b1; rot = 2; pulses = 0;
    wait_aligned(80, "relock_after_slip_abort");
    check("relock_pulses", pulses, 2);

    // PLL drop during WAIT.
    restart(2);
    wait_pulse(20, "pulse_before_wait_abort");
    step(); step();
    pll_i = 1'b0; p0 = pulses;
    step();
    check("wait_abort_bitslip", bs_o, 0);
    check("wait_abort_count", sc_o, 0);
    for (int i = 0; i < 4; i++) step();
    check("wait_abort_no_pulse", pulses, p0);
    pll_i = 1'b1; rot = 2; pulses = 0;
    wait_aligned(80, "relock_after_wait_abort");
    check("relock_pulses_2", pulses, 2);

    // Abort in the same cycle as a mismatch suppresses the pulse.
    restart(2);
    step();
    dv_i = 1'b1; q_i = rotl(2); pll_i = 1'b0;
    step();
    check("abort_suppresses_pulse", bs_o, 0);
    pll_i = 1'b1;

    // Asynchronous reset mid-pulse.
    wait_pulse(20, "pulse_before_reset");
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_bitslip", bs_o, 0);
    check("async_reset_count", sc_o, 0);
    model_reset(); bs_seen = 1'b0;
    step();
    rst_n = 1'b1;

    // Locked data forwarding with a valid gap and mismatching data.
    rot = 0; q_mode = 0; q_i = rotl(0); pulses = 0;
    wait_aligned(40, "lock_for_data");
    dv_i = 1'b1; q_i = 4'hA;
    step();
    check("fwd_a", do_o, 4'hA);
    check("fwd_a_valid", dov_o, 1);
    dv_i = 1'b0; q_i = 4'h3;
    step();
    check("gap_hold", do_o, 4'hA);
    check("gap_valid_low", dov_o, 0);
    dv_i = 1'b1; q_i = 4'h5;
    step();
    check("fwd_5", do_o, 4'h5);
    dv_i = 1'b1; q_i = 4'hC;
    step();
    check("fwd_c", do_o, 4'hC);
    check("locked_holds", al_o, 1);
    check("locked_no_slip", pulses, 0);

    // Random soak with enable/lock drops.
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) begin
        q_mode = $urandom_range(0, 2);
        rot    = $urandom_range(0, 3);
        dv_pct = $urandom_range(30, 100);
      end
      pll_i = ($urandom_range(99) < 97);
      en_i  = ($urandom_range(99) < 97);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
